// File: rtl/frame_update_sched.sv
// frame_update_sched: per-frame start/done sequencer for game update engines (rev 1.0).
// Optional FRAME_SCHED_OVR_CNT_EN adds a saturating overrun_cnt output.
`default_nettype none

module frame_update_sched #(
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_in,
  input  logic                   enable,
  input  logic [NUM_CLIENTS-1:0] client_mask,
  input  logic [NUM_CLIENTS-1:0] done,
  output logic [NUM_CLIENTS-1:0] start,
  output logic                   busy,
  output logic [3:0]             active_idx,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout,
  output logic [15:0]            frame_cnt
`ifdef FRAME_SCHED_OVR_CNT_EN
  ,
  output logic [7:0]             overrun_cnt
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [NUM_CLIENTS-1:0] r_mask;
  logic [NUM_CLIENTS-1:0] r_done;
  logic [WD_W-1:0]        r_wd;

  // {found, index} of the lowest set bit of m at or above position lo
  function automatic logic [4:0] find_set(input logic [NUM_CLIENTS-1:0] m, input int lo);
    logic [4:0] r;
    r = 5'd0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [4:0] w_first;
  logic [4:0] w_next;
  logic       w_active;
  logic       w_hit;
  logic       w_expire;

  assign w_first  = find_set(client_mask, 0);
  assign w_next   = find_set(r_mask, int'(active_idx) + 1);
  assign w_active = (r_state != IDLE) || busy;
  assign w_hit    = |(r_done & (NUM_CLIENTS'(1) << active_idx));
  assign w_expire = (r_wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_done     <= '0;
      r_wd       <= '0;
      start      <= '0;
      busy       <= 1'b0;
      active_idx <= 4'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      frame_cnt  <= 16'd0;
`ifdef FRAME_SCHED_OVR_CNT_EN
      overrun_cnt <= 8'd0;
`endif
    end else begin
      start      <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= tick_in && w_active;
`ifdef FRAME_SCHED_OVR_CNT_EN
      if (tick_in && w_active && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
`endif
      // done is only captured while waiting, so a pulse during ISSUE never counts
      r_done <= (r_state == WAIT) ? done : '0;

      case (r_state)
        IDLE: begin
          if (tick_in && enable && !busy) begin
            r_mask    <= client_mask;
            frame_cnt <= frame_cnt + 16'd1;
            busy      <= 1'b1;
            if (w_first[4]) begin
              r_state    <= ISSUE;
              active_idx <= w_first[3:0];
              start      <= NUM_CLIENTS'(1) << w_first[3:0];
            end else begin
              frame_done <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end

        WAIT: begin
          r_wd <= r_wd + WD_W'(1);
          if (w_hit || w_expire) begin
            if (!w_hit) timeout <= 1'b1;
            if (w_next[4]) begin
              r_state    <= ISSUE;
              active_idx <= w_next[3:0];
              start      <= NUM_CLIENTS'(1) << w_next[3:0];
            end else begin
              r_state    <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
